haraka_req_scheduler: RTL and testbench

//  Shares one Haraka-512 core (5 rounds, 512b in, 256b out) between N_REQ requesters using round-robin.

---
 rtl/harakav2_pkg.sv | 22 ++
 rtl/haraka_req_scheduler_rr_arbiter.sv | 44 ++++
 rtl/haraka_req_scheduler.sv | 151 +++++++++++++++
 tb/tb_haraka_req_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harakav2_pkg.sv
// Shared types and constants for the Haraka-512 request scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package harakav2;

   localparam int HARAKA_MSG_W  = 512;
   localparam int HARAKA_HASH_W = 256;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      CAPTURE,
      RESP
   } haraka_sched_state_t;

   // Round-robin successor of a requester index, wrapping at n
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/haraka_req_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides whether the grant is taken.
module haraka_rr_arbiter #(
   parameter  int N_REQ = 4,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_idx,
   output logic             grant_vld
);

   logic            lo_vld;
   logic [ID_W-1:0] lo_idx;
   logic            hi_vld;
   logic [ID_W-1:0] hi_idx;

   // Lowest valid at/after ptr wins; otherwise wrap to the lowest valid overall
   always_comb begin
      lo_vld = 1'b0;
      lo_idx = '0;
      hi_vld = 1'b0;
      hi_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_vld = 1'b1;
            lo_idx = ID_W'(i);
         end
         if (req_valid[i] && (i >= int'(ptr))) begin
            hi_vld = 1'b1;
            hi_idx = ID_W'(i);
         end
      end
      grant_vld = lo_vld;
      grant_idx = hi_vld ? hi_idx : lo_idx;
      grant     = '0;
      if (lo_vld) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/haraka_req_scheduler.sv
// Round-robin share of one Haraka-512 core among N_REQ requesters; optional stats via HARAKA_SCHED_STATS_EN.
// Latency: accept at cycle 0, core_start at 1, rsp_valid from T+3; one job per T+4 cycles.
// Backpressure: rsp_ready low holds RESP; no new grant until the single result buffer drains.
module haraka_req_scheduler
   import harakav2::*;
#(
   parameter  int N_REQ = 4,
   parameter  int T     = 5,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*HARAKA_MSG_W-1:0] req_msg,
   output logic [N_REQ-1:0]              req_ready,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [HARAKA_HASH_W-1:0]      rsp_hash,
   output logic [ID_W-1:0]               rsp_id,
   output logic                          core_start,
   output logic [HARAKA_MSG_W-1:0]       core_msg,
   input  logic [HARAKA_HASH_W-1:0]      core_hash,
   input  logic                          core_done,
   output logic                          busy,
   output logic                          err
`ifdef HARAKA_SCHED_STATS_EN
   ,
   output logic [31:0]                   stat_jobs,
   output logic [31:0]                   stat_stall
`endif
);

   // The core's round count is fixed by the core instance; only sanity-check it here
   if (N_REQ < 2 || T < 1) begin : g_cfg_check
      $error("haraka_req_scheduler: N_REQ must be >= 2 and T >= 1");
   end

   haraka_sched_state_t state_q, state_d;
   logic [ID_W-1:0]          ptr_q;
   logic [ID_W-1:0]          id_q;
   logic [HARAKA_MSG_W-1:0]  msg_q;
   logic [HARAKA_HASH_W-1:0] hash_q;
   logic                     err_q;

   logic [N_REQ-1:0] arb_grant;
   logic [ID_W-1:0]  arb_idx;
   logic             arb_vld;

   haraka_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req_valid (req_valid),
      .ptr       (ptr_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .grant_vld (arb_vld)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-state strobes; grants only ever leave IDLE
   always_comb begin
      state_d    = state_q;
      req_ready  = '0;
      core_start = 1'b0;
      rsp_valid  = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_vld) begin
               req_ready = arb_grant;
               state_d   = START;
            end
         end
         START: begin
            core_start = 1'b1;
            state_d    = WAIT;
         end
         WAIT: begin
            if (core_done) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Job data: message held for the whole core run, hash captured one cycle after done
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q  <= '0;
         id_q   <= '0;
         msg_q  <= '0;
         hash_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state_q == IDLE && arb_vld) begin
            msg_q <= req_msg[arb_idx*HARAKA_MSG_W +: HARAKA_MSG_W];
            id_q  <= arb_idx;
         end
         if (state_q == CAPTURE) begin
            hash_q <= core_hash;
         end
         if (state_q == RESP && rsp_ready) begin
            ptr_q <= ID_W'(rr_next(int'(id_q), N_REQ));
         end
         if (core_done && state_q != WAIT) begin
            err_q <= 1'b1;
         end
      end
   end

   assign core_msg = msg_q;
   assign rsp_hash = hash_q;
   assign rsp_id   = id_q;
   assign busy     = (state_q != IDLE);
   assign err      = err_q;

`ifdef HARAKA_SCHED_STATS_EN
   // Saturating counters: completed responses and cycles stalled by the consumer
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_jobs  <= '0;
         stat_stall <= '0;
      end else begin
         if (rsp_valid && rsp_ready && stat_jobs != '1) begin
            stat_jobs <= stat_jobs + 32'd1;
         end
         if (rsp_valid && !rsp_ready && stat_stall != '1) begin
            stat_stall <= stat_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_haraka_req_scheduler.sv
// Self-checking bench for haraka_req_scheduler with a behavioural T-round core model.
// Latency: core model raises done T cycles after core_start, hash a function of the message.
// Backpressure: rsp_ready driven by the bench to exercise stalls.
module tb_haraka_req_scheduler;

   localparam int N_REQ = 4;
   localparam int T     = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      req_valid;
   logic [2047:0]   req_msg;
   logic [3:0]      req_ready;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [255:0]    rsp_hash;
   logic [1:0]      rsp_id;
   logic            core_start;
   logic [511:0]    core_msg;
   logic [255:0]    core_hash;
   logic            core_done;
   logic            busy;
   logic            err;
`ifdef HARAKA_SCHED_STATS_EN
   logic [31:0]     stat_jobs;
   logic [31:0]     stat_stall;
`endif

   logic            model_done;
   logic            spur_done;
   int              core_cnt;

   int total  = 0;
   int passed = 0;

   typedef struct {
      logic [1:0]   id;
      logic [255:0] hash;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [3:0] mask;
      int         seed;
      int         exp_id;
   } vec_t;
   vec_t vecs[6];

   always #5 clk = ~clk;

   haraka_req_scheduler #(.N_REQ(N_REQ), .T(T)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_msg    (req_msg),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_hash   (rsp_hash),
      .rsp_id     (rsp_id),
      .core_start (core_start),
      .core_msg   (core_msg),
      .core_hash  (core_hash),
      .core_done  (core_done),
      .busy       (busy),
      .err        (err)
`ifdef HARAKA_SCHED_STATS_EN
      ,
      .stat_jobs  (stat_jobs),
      .stat_stall (stat_stall)
`endif
   );

   // Stand-in digest: any message-dependent 256-bit function exposes a wrong latched message
   function automatic logic [255:0] mock_hash(input logic [511:0] m);
      logic [255:0] k;
      k = {8{32'h5A17C3E1}};
      return m[511:256] ^ {m[127:0], m[255:128]} ^ k;
   endfunction

   function automatic logic [511:0] mk_msg(input int idx, input int seed);
      logic [511:0] m;
      m = '0;
      if (seed != 0) begin
         for (int w = 0; w < 16; w++) begin
            m[w*32 +: 32] = seed * 32'h9E3779B9 + w * 32'h01000193 + idx * 32'h7F4A7C15;
         end
      end
      return m;
   endfunction

   // Core model: done pulses in cycle start+T, hash held until the next run
   always @(posedge clk) begin
      if (rst) begin
         core_cnt   <= 0;
         model_done <= 1'b0;
         core_hash  <= '0;
      end else begin
         model_done <= 1'b0;
         if (core_start) begin
            core_cnt <= T - 1;
         end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
               model_done <= 1'b1;
               core_hash  <= mock_hash(core_msg);
            end
         end
      end
   end
   assign core_done = model_done | spur_done;

   task automatic check(input bit ok, input string nm, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Scoreboard: every response handshake must match the oldest outstanding job
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            check(1'b0, "unexpected response", {254'd0, rsp_id}, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check(rsp_id == e.id, "rsp_id", rsp_id, e.id);
            check(rsp_hash == e.hash, "rsp_hash", rsp_hash, e.hash);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_msgs(input int seed);
      for (int i = 0; i < 4; i++) req_msg[i*512 +: 512] = mk_msg(i, seed);
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b1; spur_done = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 80) begin
         tick();
         n++;
      end
      check(sb.size() == 0, {nm, " drain"}, sb.size(), 0);
   endtask

   task automatic run_job(input logic [3:0] mask, input int seed, input int exp_id, input string nm);
      int lat;
      int extra_start;
      logic [3:0] oh;
      oh = 4'b0001 << exp_id;
      tick();
      drive_msgs(seed);
      req_valid = mask;
      @(negedge clk);
      check(req_ready == oh, {nm, " grant"}, req_ready, oh);
      sb.push_back('{id: 2'(exp_id), hash: mock_hash(mk_msg(exp_id, seed))});
      tick();
      req_valid = '0;
      @(negedge clk);
      check(core_start && req_ready == '0, {nm, " start"}, {core_start, req_ready}, 5'b10000);
      lat = 1;
      extra_start = 0;
      while (!rsp_valid && lat < 40) begin
         tick();
         @(negedge clk);
         lat++;
         if (core_start) extra_start++;
      end
      check(lat == 8, {nm, " latency"}, lat, 8);
      check(extra_start == 0, {nm, " single start"}, extra_start, 0);
   endtask

   initial begin
      int n, cyc, prev, got, exp_g, bad_stab, bad_rdy, bad_busy;
      logic [255:0] h0;
      logic [1:0]   i0;
      logic [3:0]   oh;

      vecs[0] = '{mask: 4'b0100, seed: 0, exp_id: 2};
      vecs[1] = '{mask: 4'b0011, seed: 3, exp_id: 0};
      vecs[2] = '{mask: 4'b0011, seed: 4, exp_id: 1};
      vecs[3] = '{mask: 4'b1001, seed: 6, exp_id: 3};
      vecs[4] = '{mask: 4'b1010, seed: 8, exp_id: 1};
      vecs[5] = '{mask: 4'b0010, seed: 2, exp_id: 1};

      rst = 1'b1; req_valid = '0; req_msg = '0; rsp_ready = 1'b1; spur_done = 1'b0;
      do_reset();

      // Reset state
      @(negedge clk);
      check(req_ready == '0 && !rsp_valid && !core_start, "reset strobes", {req_ready, rsp_valid, core_start}, 0);
      check(!busy && !err, "reset busy/err", {busy, err}, 0);
      check(rsp_hash == '0 && rsp_id == '0, "reset rsp data", {rsp_id, rsp_hash}, 0);
      check(core_msg == '0, "reset core_msg", core_msg, 0);

      // Single jobs across patterns, vec0 is the msg=0 job on requester 2
      for (int i = 0; i < 6; i++) begin
         run_job(vecs[i].mask, vecs[i].seed, vecs[i].exp_id, $sformatf("vec%0d", i));
      end
      wait_drain("table");

      // All four valid continuously: order 0,1,2,3,0 spaced T+4 apart
      do_reset();
      tick();
      drive_msgs(5);
      req_valid = 4'b1111;
      cyc = 0; prev = 0; got = 0; exp_g = 0;
      while (got < 5 && cyc < 100) begin
         @(negedge clk);
         if (req_ready != '0) begin
            oh = 4'b0001 << exp_g;
            check(req_ready == oh, "rr order", req_ready, oh);
            if (got > 0) check(cyc - prev == 9, "rr spacing", cyc - prev, 9);
            sb.push_back('{id: 2'(exp_g), hash: mock_hash(mk_msg(exp_g, 5))});
            prev = cyc;
            got++;
            exp_g = (exp_g + 1) % 4;
         end
         tick();
         cyc++;
      end
      check(got == 5, "rr grants", got, 5);
      req_valid = '0;
      wait_drain("rr");

      // Backpressure: ptr is 1, only requester 0 valid, then requester 1 tempts during stall
      tick();
      rsp_ready = 1'b0;
      drive_msgs(7);
      req_valid = 4'b0001;
      @(negedge clk);
      check(req_ready == 4'b0001, "bp grant", req_ready, 4'b0001);
      sb.push_back('{id: 2'd0, hash: mock_hash(mk_msg(0, 7))});
      tick();
      req_valid = 4'b0010;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 40) begin
         tick();
         @(negedge clk);
         n++;
      end
      check(rsp_valid, "bp rsp_valid", rsp_valid, 1);
      h0 = rsp_hash;
      i0 = rsp_id;
      check(h0 == mock_hash(mk_msg(0, 7)) && i0 == 2'd0, "bp held result", {i0, h0}, {2'd0, mock_hash(mk_msg(0, 7))});
      bad_stab = 0; bad_rdy = 0; bad_busy = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         @(negedge clk);
         if (rsp_hash != h0 || rsp_id != i0) bad_stab++;
         if (req_ready != '0) bad_rdy++;
         if (!busy || !rsp_valid) bad_busy++;
      end
      check(bad_stab == 0, "bp stable", bad_stab, 0);
      check(bad_rdy == 0, "bp no grant", bad_rdy, 0);
      check(bad_busy == 0, "bp busy", bad_busy, 0);
      tick();
      rsp_ready = 1'b1;
      @(negedge clk);
      check(rsp_valid && req_ready == '0, "bp handshake cycle", {rsp_valid, req_ready}, 5'b10000);
      tick();
      @(negedge clk);
      check(req_ready == 4'b0010, "bp grant after drain", req_ready, 4'b0010);
      sb.push_back('{id: 2'd1, hash: mock_hash(mk_msg(1, 7))});
      tick();
      req_valid = '0;
      wait_drain("bp");

      // Reset mid-run: ptr is 2, job on requester 3 aborted at cycle 4
      tick();
      drive_msgs(9);
      req_valid = 4'b1000;
      @(negedge clk);
      check(req_ready == 4'b1000, "abort grant", req_ready, 4'b1000);
      tick();
      req_valid = '0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check(!busy && !core_start && !rsp_valid && req_ready == '0, "abort idle", {busy, core_start, rsp_valid, req_ready}, 0);
      check(core_msg == '0 && rsp_hash == '0 && rsp_id == '0, "abort data clear", {rsp_id, core_msg[255:0]}, 0);
      run_job(4'b1111, 11, 0, "post-abort");
      wait_drain("abort");

      // Spurious core_done in IDLE sets sticky err without disturbing jobs
      tick();
      @(negedge clk);
      check(!err, "err clean", err, 0);
      tick();
      spur_done = 1'b1;
      tick();
      spur_done = 1'b0;
      @(negedge clk);
      check(err && !busy, "err set", {err, busy}, 2'b10);
      tick();
      tick();
      @(negedge clk);
      check(err, "err sticky", err, 1);
      run_job(4'b0100, 13, 2, "post-err");
      wait_drain("err");
      check(err, "err still set", err, 1);

`ifdef HARAKA_SCHED_STATS_EN
      do_reset();
      @(negedge clk);
      check(stat_jobs == 0 && stat_stall == 0, "stats reset", {stat_jobs, stat_stall}, 0);
      tick();
      rsp_ready = 1'b0;
      drive_msgs(15);
      req_valid = 4'b0001;
      @(negedge clk);
      sb.push_back('{id: 2'd0, hash: mock_hash(mk_msg(0, 15))});
      tick();
      req_valid = '0;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 40) begin
         tick();
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 4; k++) tick();
      tick();
      rsp_ready = 1'b1;
      tick();
      run_job(4'b0010, 16, 1, "stats job2");
      run_job(4'b0100, 17, 2, "stats job3");
      wait_drain("stats");
      check(stat_jobs == 32'd3, "stat_jobs", stat_jobs, 3);
      check(stat_stall == 32'd5, "stat_stall", stat_stall, 5);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
